// File: rtl/ahb_master_addr_gen_if.sv
// Command, AHB-Lite master bus and data-path beat signals for ahb_master_addr_gen.
// "master" is the sequencer's view; "slave" is the view of whatever drives the bus side.
interface ahb_master_addr_gen_if #(
  parameter int unsigned AHB_ADDRESS_WIDTH = 32
);
  logic                         req_valid;
  logic                         req_ready;
  logic [AHB_ADDRESS_WIDTH-1:0] req_addr;
  logic [2:0]                   req_burst;
  logic [2:0]                   req_size;
  logic                         req_write;
  logic [7:0]                   req_len;

  logic [AHB_ADDRESS_WIDTH-1:0] HADDR;
  logic [1:0]                   HTRANS;
  logic [2:0]                   HBURST;
  logic [2:0]                   HSIZE;
  logic                         HWRITE;
  logic                         HREADY;
  logic                         HRESP;

  logic                         dbeat_valid;
  logic                         dbeat_last;
  logic [2:0]                   dbeat_lo_lane;
  logic [2:0]                   dbeat_hi_lane;
  logic                         cmd_done;
  logic                         cmd_err;

  modport master (
    input  req_valid, req_addr, req_burst, req_size, req_write, req_len, HREADY, HRESP,
    output req_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE,
    output dbeat_valid, dbeat_last, dbeat_lo_lane, dbeat_hi_lane, cmd_done, cmd_err
  );

  modport slave (
    output req_valid, req_addr, req_burst, req_size, req_write, req_len, HREADY, HRESP,
    input  req_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE,
    input  dbeat_valid, dbeat_last, dbeat_lo_lane, dbeat_hi_lane, cmd_done, cmd_err
  );
endinterface

// File: rtl/ahb_master_addr_gen.sv
// AHB-Lite master address-phase sequencer: takes one burst command, issues it beat by beat and
// tracks the pipelined data phase to report per-beat byte lanes and command completion.
module ahb_master_addr_gen #(
  parameter int unsigned AHB_ADDRESS_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH    = 64
) (
  input logic                   clk,
  input logic                   rst,
  ahb_master_addr_gen_if.master bus
);

  localparam int unsigned AW       = AHB_ADDRESS_WIDTH;
  localparam logic [2:0]  MAX_SIZE = 3'($clog2(AHB_DATA_WIDTH / 8));

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_INCR   = 3'd1;
  localparam logic [2:0] BURST_WRAP4  = 3'd2;
  localparam logic [2:0] BURST_INCR4  = 3'd3;
  localparam logic [2:0] BURST_WRAP8  = 3'd4;
  localparam logic [2:0] BURST_INCR8  = 3'd5;
  localparam logic [2:0] BURST_INCR16 = 3'd7;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic [1:0]    htrans_q, htrans_d;
  logic [2:0]    hburst_q, hburst_d;
  logic [2:0]    hsize_q, hsize_d;
  logic          hwrite_q, hwrite_d;
  logic [8:0]    beats_left_q, beats_left_d;
  logic [7:0]    wrap_mask_q, wrap_mask_d;
  logic          illegal_q, illegal_d;

  // Data-phase tracker: one outstanding beat behind the address phase.
  logic          trk_valid_q, trk_valid_d;
  logic [2:0]    trk_lane_q, trk_lane_d;
  logic [1:0]    trk_size_q, trk_size_d;
  logic          trk_last_q, trk_last_d;

  // Command decode
  logic [8:0]  req_beats;
  logic [11:0] req_span;
  logic [2:0]  req_align;
  logic        req_fixed_incr;
  logic        req_illegal;

  always_comb begin
    case (bus.req_burst)
      BURST_SINGLE:              req_beats = 9'd1;
      BURST_INCR:                req_beats = (bus.req_len == 8'd0) ? 9'd256 : {1'b0, bus.req_len};
      BURST_WRAP4, BURST_INCR4:  req_beats = 9'd4;
      BURST_WRAP8, BURST_INCR8:  req_beats = 9'd8;
      default:                   req_beats = 9'd16;
    endcase
  end

  assign req_span       = 12'(req_beats) << bus.req_size[1:0];
  assign req_align      = ~(3'b111 << bus.req_size[1:0]);
  assign req_fixed_incr = (bus.req_burst == BURST_INCR4) || (bus.req_burst == BURST_INCR8) ||
                          (bus.req_burst == BURST_INCR16);
  // Fixed-length INCR must fit inside the current 1KB page; undefined INCR restarts instead.
  assign req_illegal    = (bus.req_size > MAX_SIZE) || (|(bus.req_addr[2:0] & req_align)) ||
                          (req_fixed_incr && ((12'(bus.req_addr[9:0]) + req_span) > 12'd1024));

  // Next-beat address
  logic [AW-1:0] sz_bytes;
  logic [AW-1:0] addr_sum;
  logic [AW-1:0] wmask;
  logic [AW-1:0] next_addr;
  logic          is_wrap;

  assign sz_bytes  = AW'(1) << hsize_q[1:0];
  assign addr_sum  = haddr_q + sz_bytes;
  assign wmask     = AW'(wrap_mask_q);
  assign is_wrap   = !hburst_q[0] && (hburst_q != BURST_SINGLE);
  assign next_addr = is_wrap ? ((haddr_q & ~wmask) | (addr_sum & wmask)) : addr_sum;

  logic accept;
  logic trk_done;
  logic err_first;
  logic dbeat_ok;

  assign accept    = htrans_q[1] && bus.HREADY;
  assign trk_done  = trk_valid_q && bus.HREADY;
  assign err_first = trk_valid_q && !bus.HREADY && (bus.HRESP == RESP_ERROR);
  assign dbeat_ok  = trk_done && (bus.HRESP == RESP_OKAY);

  always_comb begin
    state_d      = state_q;
    haddr_d      = haddr_q;
    htrans_d     = htrans_q;
    hburst_d     = hburst_q;
    hsize_d      = hsize_q;
    hwrite_d     = hwrite_q;
    beats_left_d = beats_left_q;
    wrap_mask_d  = wrap_mask_q;
    illegal_d    = 1'b0;
    trk_valid_d  = trk_valid_q;
    trk_lane_d   = trk_lane_q;
    trk_size_d   = trk_size_q;
    trk_last_d   = trk_last_q;

    if (bus.HREADY) begin
      trk_valid_d = accept;
      if (accept) begin
        trk_lane_d = haddr_q[2:0];
        trk_size_d = hsize_q[1:0];
        trk_last_d = (beats_left_q == 9'd0);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (req_illegal) begin
            illegal_d = 1'b1;
          end else begin
            haddr_d      = bus.req_addr;
            htrans_d     = TRANS_NONSEQ;
            hburst_d     = bus.req_burst;
            hsize_d      = bus.req_size;
            hwrite_d     = bus.req_write;
            beats_left_d = req_beats - 9'd1;
            wrap_mask_d  = 8'(req_span - 12'd1);
            state_d      = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (err_first) begin
          htrans_d = TRANS_IDLE;
          state_d  = S_ERR;
        end else if (accept) begin
          if (beats_left_q != 9'd0) begin
            haddr_d      = next_addr;
            htrans_d     = (!is_wrap && (next_addr[9:0] == 10'd0)) ? TRANS_NONSEQ : TRANS_SEQ;
            beats_left_d = beats_left_q - 9'd1;
          end else begin
            htrans_d = TRANS_IDLE;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (err_first) begin
          state_d = S_ERR;
        end else if (dbeat_ok && trk_last_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        // Second ERROR cycle closes out the command.
        if (bus.HREADY) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      haddr_q      <= '0;
      htrans_q     <= TRANS_IDLE;
      hburst_q     <= BURST_SINGLE;
      hsize_q      <= 3'd0;
      hwrite_q     <= 1'b0;
      beats_left_q <= '0;
      wrap_mask_q  <= '0;
      illegal_q    <= 1'b0;
      trk_valid_q  <= 1'b0;
      trk_lane_q   <= '0;
      trk_size_q   <= '0;
      trk_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      haddr_q      <= haddr_d;
      htrans_q     <= htrans_d;
      hburst_q     <= hburst_d;
      hsize_q      <= hsize_d;
      hwrite_q     <= hwrite_d;
      beats_left_q <= beats_left_d;
      wrap_mask_q  <= wrap_mask_d;
      illegal_q    <= illegal_d;
      trk_valid_q  <= trk_valid_d;
      trk_lane_q   <= trk_lane_d;
      trk_size_q   <= trk_size_d;
      trk_last_q   <= trk_last_d;
    end
  end

  logic [2:0] lane_hi;
  assign lane_hi = trk_lane_q + ~(3'b111 << trk_size_q);

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.HADDR         = haddr_q;
  assign bus.HTRANS        = htrans_q;
  assign bus.HBURST        = hburst_q;
  assign bus.HSIZE         = hsize_q;
  assign bus.HWRITE        = hwrite_q;
  assign bus.dbeat_valid   = dbeat_ok;
  assign bus.dbeat_last    = dbeat_ok && trk_last_q;
  assign bus.dbeat_lo_lane = dbeat_ok ? trk_lane_q : 3'd0;
  assign bus.dbeat_hi_lane = dbeat_ok ? lane_hi : 3'd0;
  assign bus.cmd_done      = illegal_q || (trk_done && ((bus.HRESP == RESP_ERROR) || trk_last_q));
  assign bus.cmd_err       = illegal_q || (trk_done && (bus.HRESP == RESP_ERROR));

endmodule
